rename_stage: RTL and testbench

Two-wide register rename stage directly upstream of the reservation station. Each cycle it accepts up to two decoded instructions with 5-bit architectural register fields. It maps their sources through a register alias table (RAT) and allocates fresh 6-bit physical destinations from a 64-entry free list. It then presents the renamed pair to the reservation station one cycle later, together with the `free_pool` vector the reservation station consumes. Physical registers come back to the free list through two retire ports.

---
 rtl/rename_stage.sv | 144 ++++++++++++++
 tb/tb_rename_stage.sv | 333 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rename_stage.sv
// Two-wide register rename: RAT lookup with intra-pair bypass, lowest-first
// free-list allocation, one-cycle registered hand-off to the reservation station.
module rename_stage (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    input  logic [4:0]  rs1_1, rs2_1, rd_1,
    input  logic [4:0]  rs1_2, rs2_2, rd_2,
    input  logic [31:0] imm_1, imm_2,
    input  logic [2:0]  alu_op_1, alu_op_2,
    input  logic [6:0]  opcode_1, opcode_2,
    input  logic        rs_full,
    input  logic        ret_valid_1, ret_valid_2,
    input  logic [5:0]  ret_preg_1, ret_preg_2,
    output logic        stall,
    output logic [5:0]  rs1_o_1, rs2_o_1, rd_o_1, old_rd_o_1,
    output logic [5:0]  rs1_o_2, rs2_o_2, rd_o_2, old_rd_o_2,
    output logic [31:0] imm_o_1, imm_o_2,
    output logic [2:0]  alu_op_o_1, alu_op_o_2,
    output logic [6:0]  opcode_o_1, opcode_o_2,
    output logic        out_valid,
    output logic [63:0] free_pool,
    output logic [6:0]  free_count
);
    localparam int NUM_PREG = 64;
    localparam int NUM_AREG = 32;
    localparam logic [6:0] OPC_SW = 7'b0100011;

    typedef struct packed {
        logic [5:0]  rs1, rs2, rd, old_rd;
        logic [31:0] imm;
        logic [2:0]  alu_op;
        logic [6:0]  opcode;
    } slot_t;

    logic [NUM_AREG-1:0][5:0] rat_q, rat_d;
    logic [NUM_PREG-1:0]      free_q, free_d, alloc_mask, ret_mask;
    logic [6:0]               cnt_q, cnt_d;
    logic                     vld_q;
    slot_t                    s1_q, s1_d, s2_q, s2_d;
    logic                     need_1, need_2, accept;
    logic [1:0]               needed;
    logic [5:0]               first, second, tag_1, tag_2;

    function automatic logic [5:0] lowest(input logic [NUM_PREG-1:0] v);
        lowest = '0;
        for (int i = NUM_PREG-1; i >= 0; i--)
            if (v[i]) lowest = 6'(i);
    endfunction

    function automatic logic [6:0] popcnt(input logic [NUM_PREG-1:0] v);
        popcnt = '0;
        for (int i = 0; i < NUM_PREG; i++)
            popcnt = popcnt + 7'(v[i]);
    endfunction

    always_comb begin
        need_1 = (opcode_1 != OPC_SW) && (rd_1 != 5'd0);
        need_2 = (opcode_2 != OPC_SW) && (rd_2 != 5'd0);
        needed = {1'b0, need_1} + {1'b0, need_2};
        stall  = in_valid && (rs_full || (cnt_q < {5'd0, needed}));
        accept = in_valid && !stall;

        // Tags are handed out in slot order to the slots that actually write.
        first  = lowest(free_q);
        second = lowest(free_q & ~(64'd1 << first));
        tag_1  = need_1 ? first : 6'd0;
        tag_2  = !need_2 ? 6'd0 : (need_1 ? second : first);

        s1_d        = '0;
        s1_d.rs1    = rat_q[rs1_1];
        s1_d.rs2    = rat_q[rs2_1];
        s1_d.rd     = tag_1;
        s1_d.old_rd = need_1 ? rat_q[rd_1] : 6'd0;
        s1_d.imm    = imm_1;
        s1_d.alu_op = alu_op_1;
        s1_d.opcode = opcode_1;

        // Slot 2 sees slot 1's rename as if it had already been committed.
        s2_d        = '0;
        s2_d.rs1    = (need_1 && rs1_2 == rd_1) ? tag_1 : rat_q[rs1_2];
        s2_d.rs2    = (need_1 && rs2_2 == rd_1) ? tag_1 : rat_q[rs2_2];
        s2_d.rd     = tag_2;
        s2_d.old_rd = !need_2 ? 6'd0 : ((need_1 && rd_2 == rd_1) ? tag_1 : rat_q[rd_2]);
        s2_d.imm    = imm_2;
        s2_d.alu_op = alu_op_2;
        s2_d.opcode = opcode_2;

        alloc_mask = '0;
        if (need_1) alloc_mask[tag_1] = 1'b1;
        if (need_2) alloc_mask[tag_2] = 1'b1;
        ret_mask = '0;
        if (ret_valid_1 && ret_preg_1 != 6'd0) ret_mask[ret_preg_1] = 1'b1;
        if (ret_valid_2 && ret_preg_2 != 6'd0) ret_mask[ret_preg_2] = 1'b1;

        // A retire of an already-free tag is a no-op, so allocation wins over it.
        rat_d  = rat_q;
        free_d = free_q | ret_mask;
        if (accept) begin
            if (need_1) rat_d[rd_1] = tag_1;
            if (need_2) rat_d[rd_2] = tag_2;
            free_d = free_d & ~alloc_mask;
        end
        cnt_d = popcnt(free_d);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int a = 0; a < NUM_AREG; a++) rat_q[a] <= 6'(a);
            free_q <= {{32{1'b1}}, {32{1'b0}}};
            cnt_q  <= 7'd32;
            vld_q  <= 1'b0;
            s1_q   <= '0;
            s2_q   <= '0;
        end else begin
            rat_q  <= rat_d;
            free_q <= free_d;
            cnt_q  <= cnt_d;
            vld_q  <= accept;
            if (accept) begin
                s1_q <= s1_d;
                s2_q <= s2_d;
            end
        end
    end

    assign out_valid  = vld_q;
    assign free_pool  = free_q;
    assign free_count = cnt_q;
    assign rs1_o_1    = s1_q.rs1;
    assign rs2_o_1    = s1_q.rs2;
    assign rd_o_1     = s1_q.rd;
    assign old_rd_o_1 = s1_q.old_rd;
    assign imm_o_1    = s1_q.imm;
    assign alu_op_o_1 = s1_q.alu_op;
    assign opcode_o_1 = s1_q.opcode;
    assign rs1_o_2    = s2_q.rs1;
    assign rs2_o_2    = s2_q.rs2;
    assign rd_o_2     = s2_q.rd;
    assign old_rd_o_2 = s2_q.old_rd;
    assign imm_o_2    = s2_q.imm;
    assign alu_op_o_2 = s2_q.alu_op;
    assign opcode_o_2 = s2_q.opcode;
endmodule

// File: tb/tb_rename_stage.sv
// Rename stage bench: directed scenarios plus random traffic against a
// sequential-rename reference model, compared every cycle.
module tb_rename_stage;
    localparam logic [6:0] ADD = 7'b0110011, ADDI = 7'b0010011, SW = 7'b0100011;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, in_valid, rs_full;
    logic [4:0]  t_rs1[2], t_rs2[2], t_rd[2];
    logic [31:0] t_imm[2];
    logic [2:0]  t_alu[2];
    logic [6:0]  t_op[2];
    logic        t_rv[2];
    logic [5:0]  t_rp[2];

    logic        stall, out_valid;
    logic [5:0]  o_rs1[2], o_rs2[2], o_rd[2], o_old[2];
    logic [31:0] o_imm[2];
    logic [2:0]  o_alu[2];
    logic [6:0]  o_op[2];
    logic [63:0] free_pool;
    logic [6:0]  free_count;

    rename_stage dut (
        .clk(clk), .rst(rst), .in_valid(in_valid),
        .rs1_1(t_rs1[0]), .rs2_1(t_rs2[0]), .rd_1(t_rd[0]),
        .rs1_2(t_rs1[1]), .rs2_2(t_rs2[1]), .rd_2(t_rd[1]),
        .imm_1(t_imm[0]), .imm_2(t_imm[1]),
        .alu_op_1(t_alu[0]), .alu_op_2(t_alu[1]),
        .opcode_1(t_op[0]), .opcode_2(t_op[1]),
        .rs_full(rs_full),
        .ret_valid_1(t_rv[0]), .ret_valid_2(t_rv[1]),
        .ret_preg_1(t_rp[0]), .ret_preg_2(t_rp[1]),
        .stall(stall),
        .rs1_o_1(o_rs1[0]), .rs2_o_1(o_rs2[0]), .rd_o_1(o_rd[0]), .old_rd_o_1(o_old[0]),
        .rs1_o_2(o_rs1[1]), .rs2_o_2(o_rs2[1]), .rd_o_2(o_rd[1]), .old_rd_o_2(o_old[1]),
        .imm_o_1(o_imm[0]), .imm_o_2(o_imm[1]),
        .alu_op_o_1(o_alu[0]), .alu_op_o_2(o_alu[1]),
        .opcode_o_1(o_op[0]), .opcode_o_2(o_op[1]),
        .out_valid(out_valid), .free_pool(free_pool), .free_count(free_count)
    );

    int n_cmp = 0, n_bad = 0;
    bit armed = 0;

    // Reference state: RAT, free set, last accepted pair, and retire backlog.
    logic [5:0]  m_rat[32];
    bit          m_free[64];
    bit          e_valid;
    logic [5:0]  e_rs1[2], e_rs2[2], e_rd[2], e_old[2];
    logic [31:0] e_imm[2];
    logic [2:0]  e_alu[2];
    logic [6:0]  e_op[2];
    logic [5:0]  q_ret[$];

    task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, got, exp, $time);
        end
    endtask

    function automatic bit need(input int k);
        return (t_op[k] != SW) && (t_rd[k] != 5'd0);
    endfunction

    function automatic int count_free();
        int c = 0;
        for (int p = 0; p < 64; p++) c += int'(m_free[p]);
        return c;
    endfunction

    function automatic logic [63:0] pool_vec();
        logic [63:0] v;
        for (int p = 0; p < 64; p++) v[p] = m_free[p];
        return v;
    endfunction

    task automatic compare();
        bit exp_stall;
        exp_stall = in_valid && (rs_full || count_free() < int'(need(0)) + int'(need(1)));
        chk("stall", stall, exp_stall);
        chk("out_valid", out_valid, e_valid);
        chk("free_pool", free_pool, pool_vec());
        chk("free_count", free_count, count_free());
        if (e_valid) begin
            for (int k = 0; k < 2; k++) begin
                chk($sformatf("rs1_o_%0d", k+1), o_rs1[k], e_rs1[k]);
                chk($sformatf("rs2_o_%0d", k+1), o_rs2[k], e_rs2[k]);
                chk($sformatf("rd_o_%0d", k+1), o_rd[k], e_rd[k]);
                chk($sformatf("old_rd_o_%0d", k+1), o_old[k], e_old[k]);
                chk($sformatf("imm_o_%0d", k+1), o_imm[k], e_imm[k]);
                chk($sformatf("alu_op_o_%0d", k+1), o_alu[k], e_alu[k]);
                chk($sformatf("opcode_o_%0d", k+1), o_op[k], e_op[k]);
            end
        end
    endtask

    // Rename the two slots one after the other against a live RAT; slot 2
    // therefore sees slot 1's write, which covers bypass and WAW.
    task automatic model_step();
        bit pre[64];
        int fl[$];
        int idx, cnt;
        bit n[2];
        if (rst) begin
            for (int a = 0; a < 32; a++) m_rat[a] = 6'(a);
            for (int p = 0; p < 64; p++) m_free[p] = (p >= 32);
            e_valid = 0;
            q_ret.delete();
            return;
        end
        pre = m_free;
        cnt = count_free();
        n[0] = need(0);
        n[1] = need(1);
        e_valid = in_valid && !(rs_full || cnt < int'(n[0]) + int'(n[1]));
        if (e_valid) begin
            for (int p = 0; p < 64; p++) if (m_free[p]) fl.push_back(p);
            idx = 0;
            for (int k = 0; k < 2; k++) begin
                e_rs1[k] = m_rat[t_rs1[k]];
                e_rs2[k] = m_rat[t_rs2[k]];
                e_imm[k] = t_imm[k];
                e_alu[k] = t_alu[k];
                e_op[k]  = t_op[k];
                if (n[k]) begin
                    e_rd[k]  = 6'(fl[idx]);
                    idx++;
                    e_old[k] = m_rat[t_rd[k]];
                    m_rat[t_rd[k]] = e_rd[k];
                    m_free[e_rd[k]] = 0;
                    q_ret.push_back(e_old[k]);
                end else begin
                    e_rd[k]  = 6'd0;
                    e_old[k] = 6'd0;
                end
            end
        end
        for (int k = 0; k < 2; k++)
            if (t_rv[k] && t_rp[k] != 6'd0 && !pre[t_rp[k]]) m_free[t_rp[k]] = 1;
    endtask

    task automatic step();
        @(negedge clk);
        if (armed) compare();
        model_step();
        armed = 1;
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        in_valid = 0;
        rs_full  = 0;
        for (int k = 0; k < 2; k++) begin
            t_rv[k] = 0;
            t_rp[k] = 6'd0;
        end
    endtask

    task automatic do_reset();
        rst = 1;
        idle();
        step();
        step();
        rst = 0;
    endtask

    task automatic set_pair(input logic [6:0] op1, input logic [4:0] rd1, input logic [4:0] a1,
                            input logic [4:0] b1, input logic [6:0] op2, input logic [4:0] rd2,
                            input logic [4:0] a2, input logic [4:0] b2);
        in_valid = 1;
        t_op[0] = op1; t_rd[0] = rd1; t_rs1[0] = a1; t_rs2[0] = b1;
        t_op[1] = op2; t_rd[1] = rd2; t_rs1[1] = a2; t_rs2[1] = b2;
        for (int k = 0; k < 2; k++) begin
            t_imm[k] = $urandom;
            t_alu[k] = 3'($urandom_range(7));
        end
    endtask

    initial begin
        rst = 1;
        for (int k = 0; k < 2; k++) begin
            t_rs1[k] = '0; t_rs2[k] = '0; t_rd[k] = '0; t_imm[k] = '0;
            t_alu[k] = '0; t_op[k] = '0; t_rv[k] = 0; t_rp[k] = '0;
        end
        idle();
        do_reset();
        chk("lit_reset_out_valid", out_valid, 0);
        chk("lit_reset_free_count", free_count, 32);
        chk("lit_reset_free_pool", free_pool, 64'hFFFF_FFFF_0000_0000);
        chk("lit_reset_rd_o_1", o_rd[0], 0);

        // add x1,x2,x3 / addi x4,x1,5
        set_pair(ADD, 5'd1, 5'd2, 5'd3, ADDI, 5'd4, 5'd1, 5'd0);
        t_imm[1] = 32'd5;
        step();
        idle();
        chk("lit_t1_rd_o_1", o_rd[0], 32);
        chk("lit_t1_rs1_o_1", o_rs1[0], 2);
        chk("lit_t1_rs2_o_1", o_rs2[0], 3);
        chk("lit_t1_old_rd_o_1", o_old[0], 1);
        chk("lit_t1_rd_o_2", o_rd[1], 33);
        chk("lit_t1_rs1_o_2", o_rs1[1], 32);
        chk("lit_t1_old_rd_o_2", o_old[1], 4);
        chk("lit_t1_imm_o_2", o_imm[1], 5);
        chk("lit_t1_free_count", free_count, 30);

        // WAW on x5, then read x5
        do_reset();
        set_pair(ADD, 5'd5, 5'd1, 5'd2, ADD, 5'd5, 5'd3, 5'd4);
        step();
        chk("lit_waw_rd_o_1", o_rd[0], 32);
        chk("lit_waw_rd_o_2", o_rd[1], 33);
        chk("lit_waw_old_rd_o_2", o_old[1], 32);
        set_pair(ADD, 5'd6, 5'd5, 5'd0, SW, 5'd9, 5'd5, 5'd6);
        step();
        chk("lit_waw_read_x5", o_rs1[0], 33);
        chk("lit_waw_rd_o_1b", o_rd[0], 34);
        chk("lit_waw_sw_rd_o_2", o_rd[1], 0);

        // sw / add x0: nothing allocated, RAT untouched
        set_pair(SW, 5'd7, 5'd5, 5'd6, ADD, 5'd0, 5'd1, 5'd2);
        #1 chk("lit_sw_stall", stall, 0);
        step();
        chk("lit_sw_rd_o_1", o_rd[0], 0);
        chk("lit_sw_rd_o_2", o_rd[1], 0);
        chk("lit_sw_free_count", free_count, 29);
        set_pair(ADD, 5'd7, 5'd5, 5'd6, SW, 5'd0, 5'd0, 5'd0);
        step();
        idle();
        chk("lit_sw_rat_x5", o_rs1[0], 33);
        chk("lit_sw_rat_x6", o_rs2[0], 34);

        // Drain to one free register, stall, retire p7, then accept
        do_reset();
        for (int i = 0; i < 15; i++) begin
            set_pair(ADD, 5'(1+i), 5'd0, 5'd0, ADD, 5'(16+i), 5'd0, 5'd0);
            step();
        end
        set_pair(ADD, 5'd5, 5'd0, 5'd0, SW, 5'd0, 5'd0, 5'd0);
        step();
        chk("lit_drain_count1", free_count, 1);
        set_pair(ADD, 5'd8, 5'd1, 5'd2, ADD, 5'd9, 5'd3, 5'd4);
        #1 chk("lit_drain_stall", stall, 1);
        t_rv[0] = 1; t_rp[0] = 6'd7;
        step();
        t_rv[0] = 0; t_rp[0] = 6'd0;
        chk("lit_drain_stalled_no_valid", out_valid, 0);
        chk("lit_drain_count2", free_count, 2);
        #1 chk("lit_drain_unstall", stall, 0);
        step();
        chk("lit_drain_rd_o_1", o_rd[0], 7);
        chk("lit_drain_rd_o_2", o_rd[1], 63);
        chk("lit_drain_count0", free_count, 0);
        set_pair(SW, 5'd1, 5'd1, 5'd2, SW, 5'd3, 5'd3, 5'd4);
        #1 chk("lit_empty_no_need_stall", stall, 0);
        step();
        chk("lit_empty_accept", out_valid, 1);
        set_pair(ADD, 5'd1, 5'd1, 5'd2, SW, 5'd3, 5'd3, 5'd4);
        #1 chk("lit_empty_writer_stall", stall, 1);

        // rs_full, and retire of p0 ignored
        rs_full = 1;
        set_pair(SW, 5'd1, 5'd1, 5'd2, SW, 5'd3, 5'd3, 5'd4);
        t_rv[0] = 1; t_rp[0] = 6'd0;
        #1 chk("lit_rsfull_stall", stall, 1);
        step();
        idle();
        chk("lit_rsfull_out_valid", out_valid, 0);
        chk("lit_ret0_pool0", free_pool[0], 0);

        // Reset overrides accept and retire
        set_pair(ADD, 5'd3, 5'd1, 5'd2, ADD, 5'd4, 5'd1, 5'd2);
        t_rv[0] = 1; t_rp[0] = 6'd40;
        rst = 1;
        step();
        rst = 0;
        idle();
        chk("lit_rst_out_valid", out_valid, 0);
        chk("lit_rst_free_count", free_count, 32);
        set_pair(ADD, 5'd9, 5'd9, 5'd10, SW, 5'd0, 5'd0, 5'd0);
        step();
        idle();
        chk("lit_rst_rat_identity", o_rs1[0], 9);
        chk("lit_rst_rat_identity2", o_rs2[0], 10);

        // Random traffic
        for (int c = 0; c < 4000; c++) begin
            rst = ($urandom_range(399) == 0);
            in_valid = ($urandom_range(9) < 8);
            rs_full  = ($urandom_range(9) == 0);
            for (int k = 0; k < 2; k++) begin
                case ($urandom_range(5))
                    0: t_op[k] = SW;
                    1: t_op[k] = ADDI;
                    2: t_op[k] = 7'($urandom_range(127));
                    default: t_op[k] = ADD;
                endcase
                t_rd[k]  = ($urandom_range(7) == 0) ? 5'd0 : 5'($urandom_range(31));
                t_rs1[k] = 5'($urandom_range(31));
                t_rs2[k] = 5'($urandom_range(31));
                t_imm[k] = $urandom;
                t_alu[k] = 3'($urandom_range(7));
            end
            if ($urandom_range(2) == 0) t_rs1[1] = t_rd[0];
            if ($urandom_range(3) == 0) t_rs2[1] = t_rd[0];
            if ($urandom_range(5) == 0) t_rd[1] = t_rd[0];
            for (int k = 0; k < 2; k++) begin
                if (q_ret.size() > 0 && $urandom_range(9) < 6) begin
                    t_rv[k] = 1;
                    t_rp[k] = q_ret.pop_front();
                end else if ($urandom_range(19) == 0) begin
                    t_rv[k] = 1;
                    t_rp[k] = 6'($urandom_range(63));
                end else begin
                    t_rv[k] = 0;
                    t_rp[k] = 6'($urandom_range(63));
                end
            end
            step();
        end
        rst = 0;
        idle();
        step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
